// File: rtl/crono_multicanal.sv
// crono_multicanal: N-channel HH:MM:SS countdown timer.
//   clk, Reset (sync, active high)
//   ch_sel           channel being edited / started / paused / acknowledged
//   ProgramarCrono   level, edit mode for the selected channel
//   PushInicioCrono, pausa, arriba, abajo, izquierda, derecha: acted on at rising edge
//   CronoActivo[i]   channel i counting; Ring[i] channel i ringing
//   campo_sel        cursor (0 seg, 1 min, 2 horas)
//   horasSal/minutosSal/segundosSal  BCD value of the selected channel
// Channel values are held in binary and converted to BCD on the way into the
// output registers. The borrow chain sec->min->hours is the same either way.

module crono_canal #(
  parameter int RING_SECS = 5,
  parameter int HOURS_MAX = 23
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_i,
  input  logic       sel_i,
  input  logic       prog_i,
  input  logic       ini_i,     // button edges, not yet qualified by sel_i
  input  logic       pau_i,
  input  logic       up_i,
  input  logic       dn_i,
  input  logic       izq_i,
  input  logic       der_i,
  input  logic [1:0] cur_i,
  output logic       enter_o,   // entering PROG this cycle
  output logic       edit_o,    // staying in PROG this cycle
  output logic       run_o,
  output logic       ring_o,
  output logic [6:0] h_d_o,
  output logic [5:0] m_d_o,
  output logic [5:0] s_d_o
);
  localparam int RW = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;

  typedef enum logic [2:0] {IDLE, PROG, RUN, PAUSE, RING} st_e;

  st_e        st_q, st_d;
  logic [6:0] h_q, h_d, ph_q, ph_d;
  logic [5:0] m_q, m_d, pm_q, pm_d;
  logic [5:0] s_q, s_d, ps_q, ps_d;
  logic [RW-1:0] rc_q, rc_d;
  logic       run_q, ring_q;
  logic [6:0] h_dec;
  logic [5:0] m_dec, s_dec;
  logic       nz, any_btn;

  assign nz      = (h_q != 7'd0) || (m_q != 6'd0) || (s_q != 6'd0);
  assign any_btn = ini_i | pau_i | up_i | dn_i | izq_i | der_i;

  // one-second decrement with borrow
  always_comb begin
    h_dec = h_q;
    m_dec = m_q;
    s_dec = s_q - 6'd1;
    if (s_q == 6'd0) begin
      s_dec = 6'd59;
      m_dec = m_q - 6'd1;
      if (m_q == 6'd0) begin
        m_dec = 6'd59;
        h_dec = h_q - 7'd1;
      end
    end
  end

  always_comb begin
    st_d = st_q;
    h_d = h_q;  m_d = m_q;  s_d = s_q;
    ph_d = ph_q; pm_d = pm_q; ps_d = ps_q;
    rc_d = rc_q;
    enter_o = 1'b0;
    edit_o  = 1'b0;
    case (st_q)
      IDLE: begin
        if (sel_i && prog_i) begin
          st_d = PROG;
          enter_o = 1'b1;
        end else if (sel_i && ini_i && nz) begin
          st_d = RUN;
        end
      end
      PROG: begin
        if (!(sel_i && prog_i)) begin
          // leaving edit (button released or channel deselected) latches the preset
          st_d = IDLE;
          ph_d = h_q; pm_d = m_q; ps_d = s_q;
        end else begin
          edit_o = 1'b1;
          if (up_i && !dn_i) begin
            case (cur_i)
              2'd0:    s_d = (s_q == 6'd59) ? 6'd0 : s_q + 6'd1;
              2'd1:    m_d = (m_q == 6'd59) ? 6'd0 : m_q + 6'd1;
              default: h_d = (h_q == 7'(HOURS_MAX)) ? 7'd0 : h_q + 7'd1;
            endcase
          end else if (dn_i && !up_i) begin
            case (cur_i)
              2'd0:    s_d = (s_q == 6'd0) ? 6'd59 : s_q - 6'd1;
              2'd1:    m_d = (m_q == 6'd0) ? 6'd59 : m_q - 6'd1;
              default: h_d = (h_q == 7'd0) ? 7'(HOURS_MAX) : h_q - 7'd1;
            endcase
          end
        end
      end
      RUN: begin
        // start outranks pause; a start edge while running is simply a no-op
        if (sel_i && pau_i && !ini_i) begin
          st_d = PAUSE;
        end else if (tick_i) begin
          h_d = h_dec; m_d = m_dec; s_d = s_dec;
          if (h_dec == 7'd0 && m_dec == 6'd0 && s_dec == 6'd0) begin
            st_d = RING;
            rc_d = '0;
          end
        end
      end
      PAUSE: begin
        if (sel_i && (ini_i || pau_i)) st_d = RUN;
      end
      RING: begin
        if ((sel_i && any_btn) ||
            (tick_i && rc_q == RW'(RING_SECS - 1))) begin
          st_d = IDLE;
          h_d = ph_q; m_d = pm_q; s_d = ps_q;
        end else if (tick_i) begin
          rc_d = rc_q + RW'(1);
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q <= IDLE;
      h_q <= '0;  m_q <= '0;  s_q <= '0;
      ph_q <= '0; pm_q <= '0; ps_q <= '0;
      rc_q <= '0;
      run_q <= 1'b0;
      ring_q <= 1'b0;
    end else begin
      st_q <= st_d;
      h_q <= h_d;  m_q <= m_d;  s_q <= s_d;
      ph_q <= ph_d; pm_q <= pm_d; ps_q <= ps_d;
      rc_q <= rc_d;
      run_q <= (st_d == RUN);
      ring_q <= (st_d == RING);
    end
  end

  assign run_o  = run_q;
  assign ring_o = ring_q;
  assign h_d_o  = h_d;
  assign m_d_o  = m_d;
  assign s_d_o  = s_d;
endmodule

module crono_multicanal #(
  parameter int N_CH      = 2,
  parameter int TICK_DIV  = 100_000_000,
  parameter int RING_SECS = 5,
  parameter int HOURS_MAX = 23,
  localparam int SW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic [SW-1:0]   ch_sel,
  input  logic            ProgramarCrono,
  input  logic            PushInicioCrono,
  input  logic            pausa,
  input  logic            arriba,
  input  logic            abajo,
  input  logic            izquierda,
  input  logic            derecha,
  output logic [N_CH-1:0] CronoActivo,
  output logic [N_CH-1:0] Ring,
  output logic [1:0]      campo_sel,
  output logic [7:0]      horasSal,
  output logic [7:0]      minutosSal,
  output logic [7:0]      segundosSal
);
  localparam int PW = $clog2(TICK_DIV);

  logic [5:0]    btn, btn_q, edg;   // {inicio, pausa, arriba, abajo, izq, der}
  logic [PW-1:0] pre_q, pre_d;
  logic          tick;
  logic [1:0]    cur_q, cur_d;
  logic [7:0]    hor_q, min_q, seg_q;

  logic [N_CH-1:0]      sel_v, enter_v, edit_v;
  logic [N_CH-1:0][6:0] h_d;
  logic [N_CH-1:0][5:0] m_d, s_d;
  logic [6:0]           hs;
  logic [5:0]           ms, ss;

  assign btn  = {PushInicioCrono, pausa, arriba, abajo, izquierda, derecha};
  assign edg  = btn & ~btn_q;
  assign tick = (pre_q == PW'(TICK_DIV - 1));
  assign pre_d = tick ? '0 : pre_q + PW'(1);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign sel_v[i] = (ch_sel == SW'(i));
    crono_canal #(.RING_SECS(RING_SECS), .HOURS_MAX(HOURS_MAX)) u_ch (
      .clk_i(clk), .rst_i(Reset), .tick_i(tick),
      .sel_i(sel_v[i]), .prog_i(ProgramarCrono),
      .ini_i(edg[5]), .pau_i(edg[4]), .up_i(edg[3]), .dn_i(edg[2]),
      .izq_i(edg[1]), .der_i(edg[0]), .cur_i(cur_q),
      .enter_o(enter_v[i]), .edit_o(edit_v[i]),
      .run_o(CronoActivo[i]), .ring_o(Ring[i]),
      .h_d_o(h_d[i]), .m_d_o(m_d[i]), .s_d_o(s_d[i])
    );
  end

  // cursor is shared; an arriba/abajo edge in the same cycle suppresses movement
  always_comb begin
    cur_d = cur_q;
    if (|enter_v) begin
      cur_d = 2'd0;
    end else if ((|edit_v) && !edg[3] && !edg[2]) begin
      if (edg[1] && !edg[0])      cur_d = (cur_q == 2'd2) ? 2'd0 : cur_q + 2'd1;
      else if (edg[0] && !edg[1]) cur_d = (cur_q == 2'd0) ? 2'd2 : cur_q - 2'd1;
    end
  end

  always_comb begin
    hs = '0; ms = '0; ss = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel_v[i]) begin
        hs = h_d[i]; ms = m_d[i]; ss = s_d[i];
      end
    end
  end

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [7:0] w;
    w = {1'b0, v};
    return ((w / 8'd10) << 4) | (w % 8'd10);
  endfunction

  always_ff @(posedge clk) begin
    if (Reset) begin
      btn_q <= '0;
      pre_q <= '0;
      cur_q <= '0;
      hor_q <= '0; min_q <= '0; seg_q <= '0;
    end else begin
      btn_q <= btn;
      pre_q <= pre_d;
      cur_q <= cur_d;
      hor_q <= to_bcd(hs);
      min_q <= to_bcd({1'b0, ms});
      seg_q <= to_bcd({1'b0, ss});
    end
  end

  assign campo_sel   = cur_q;
  assign horasSal    = hor_q;
  assign minutosSal  = min_q;
  assign segundosSal = seg_q;
endmodule

// File: tb/tb_crono_multicanal.sv
module tb_crono_multicanal;
  localparam int N = 2, TD = 4, RS = 3, HM = 23;
  localparam int B_INI = 0, B_PAU = 1, B_UP = 2, B_DN = 3, B_IZQ = 4, B_DER = 5;

  logic clk = 1'b0;
  logic rst, prg, ini, pau, up, dn, izq, der;
  logic [0:0] chs;
  logic [N-1:0] act, rng;
  logic [1:0] campo;
  logic [7:0] hh, mm, ss;

  crono_multicanal #(.N_CH(N), .TICK_DIV(TD), .RING_SECS(RS), .HOURS_MAX(HM)) dut (
    .clk(clk), .Reset(rst), .ch_sel(chs), .ProgramarCrono(prg),
    .PushInicioCrono(ini), .pausa(pau), .arriba(up), .abajo(dn),
    .izquierda(izq), .derecha(der),
    .CronoActivo(act), .Ring(rng), .campo_sel(campo),
    .horasSal(hh), .minutosSal(mm), .segundosSal(ss)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] h, m, s;
    logic [1:0] act, rng, campo;
  } exp_t;
  exp_t q[$];

  int total = 0, bad = 0;

  // ---- behavioural model: fields as integers, countdown through total seconds
  typedef enum {M_IDLE, M_PROG, M_RUN, M_PAUSE, M_RING} mode_t;
  mode_t md[N];
  int vh[N], vm[N], vs[N], ph[N], pm[N], ps[N], left[N];
  int cur, pc;
  bit p_ini, p_pau, p_up, p_dn, p_izq, p_der;

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  task automatic bump(input int c, input int d);
    if (cur == 0)      vs[c] = (vs[c] + d + 60) % 60;
    else if (cur == 1) vm[c] = (vm[c] + d + 60) % 60;
    else               vh[c] = (vh[c] + d + HM + 1) % (HM + 1);
  endtask

  task automatic restore(input int c);
    md[c] = M_IDLE; vh[c] = ph[c]; vm[c] = pm[c]; vs[c] = ps[c];
  endtask

  task automatic model_step();
    exp_t e;
    bit tk, ei, ep, eu, ed, el, er, entered, editing, sel;
    int t;
    e = '0;
    if (rst) begin
      for (int c = 0; c < N; c++) begin
        md[c] = M_IDLE; vh[c] = 0; vm[c] = 0; vs[c] = 0;
        ph[c] = 0; pm[c] = 0; ps[c] = 0; left[c] = 0;
      end
      cur = 0; pc = 0;
      {p_ini, p_pau, p_up, p_dn, p_izq, p_der} = '0;
    end else begin
      tk = (pc == TD - 1);
      pc = (pc + 1) % TD;
      ei = ini && !p_ini; ep = pau && !p_pau; eu = up && !p_up;
      ed = dn && !p_dn;   el = izq && !p_izq; er = der && !p_der;
      {p_ini, p_pau, p_up, p_dn, p_izq, p_der} = {ini, pau, up, dn, izq, der};
      entered = 0; editing = 0;
      for (int c = 0; c < N; c++) begin
        sel = (chs == c);
        t = vh[c] * 3600 + vm[c] * 60 + vs[c];
        case (md[c])
          M_IDLE:
            if (sel && prg) begin md[c] = M_PROG; entered = 1; end
            else if (sel && ei && t != 0) md[c] = M_RUN;
          M_PROG:
            if (!(sel && prg)) begin
              md[c] = M_IDLE; ph[c] = vh[c]; pm[c] = vm[c]; ps[c] = vs[c];
            end else begin
              editing = 1;
              if (eu && !ed) bump(c, 1);
              else if (ed && !eu) bump(c, -1);
            end
          M_RUN:
            if (sel && ep && !ei) md[c] = M_PAUSE;
            else if (tk) begin
              t = t - 1;
              vh[c] = t / 3600; vm[c] = (t / 60) % 60; vs[c] = t % 60;
              if (t == 0) begin md[c] = M_RING; left[c] = RS; end
            end
          M_PAUSE:
            if (sel && (ei || ep)) md[c] = M_RUN;
          M_RING:
            if (sel && (ei || ep || eu || ed || el || er)) restore(c);
            else if (tk) begin
              left[c] = left[c] - 1;
              if (left[c] == 0) restore(c);
            end
          default: ;
        endcase
      end
      if (entered) cur = 0;
      else if (editing && !eu && !ed) begin
        if (el && !er)      cur = (cur + 1) % 3;
        else if (er && !el) cur = (cur + 2) % 3;
      end
      for (int c = 0; c < N; c++) begin
        e.act[c] = (md[c] == M_RUN);
        e.rng[c] = (md[c] == M_RING);
      end
      e.h = bcd(vh[chs]); e.m = bcd(vm[chs]); e.s = bcd(vs[chs]);
      e.campo = 2'(cur);
    end
    q.push_back(e);
  endtask

  // ---- monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if ({hh, mm, ss} !== {e.h, e.m, e.s}) begin
          bad++;
          $display("FAIL time @%0t got=%h:%h:%h exp=%h:%h:%h", $time, hh, mm, ss, e.h, e.m, e.s);
        end
        total++;
        if ({act, rng} !== {e.act, e.rng}) begin
          bad++;
          $display("FAIL flags @%0t got act=%b ring=%b exp act=%b ring=%b", $time, act, rng, e.act, e.rng);
        end
        total++;
        if (campo !== e.campo) begin
          bad++;
          $display("FAIL campo @%0t got=%0d exp=%0d", $time, campo, e.campo);
        end
      end
    end
  end

  // ---- stimulus
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      B_INI: ini = v;
      B_PAU: pau = v;
      B_UP:  up  = v;
      B_DN:  dn  = v;
      B_IZQ: izq = v;
      default: der = v;
    endcase
  endtask

  task automatic press(input int b, input int hold = 1);
    set_btn(b, 1'b1);
    repeat (hold) step();
    set_btn(b, 1'b0);
    step();
  endtask

  initial begin
    int r;
    rst = 1; chs = 0; prg = 0;
    {ini, pau, up, dn, izq, der} = '0;
    idle(2);
    rst = 0;

    // field editing and wrap boundaries on ch0
    prg = 1; step();
    repeat (5) press(B_UP);
    press(B_DN);
    press(B_IZQ); press(B_DN); press(B_UP); press(B_UP);   // min 00->59->00->01
    press(B_IZQ); press(B_DN);                             // hours 00->23
    press(B_IZQ); press(B_DER);                            // cursor 2->0->2
    press(B_UP, 3);                                        // held: one step, 23->00
    prg = 0; step();

    // 00:01:04 run to ring and auto-return
    press(B_INI); idle(300);

    // 00:00:02: natural ring, then early exit by arriba
    prg = 1; step();
    press(B_DN); press(B_DN); press(B_IZQ); press(B_DN);
    prg = 0; step();
    press(B_INI); idle(20);
    press(B_INI); idle(9); press(B_UP); idle(4);

    // pause ch0 while ch1 is programmed and started
    prg = 1; step();
    press(B_IZQ); press(B_UP); press(B_UP);
    prg = 0; step();
    press(B_INI); idle(10); press(B_PAU); idle(40);
    chs = 1; prg = 1; step();
    repeat (3) press(B_UP);
    prg = 0; step();
    press(B_INI);
    chs = 0; press(B_PAU); idle(40);

    // channel switch mid-edit
    prg = 1; step(); press(B_UP);
    chs = 1; step(); step(); press(B_UP);
    prg = 0; step(); chs = 0;

    // zero start stays idle; reset mid-run
    rst = 1; step(); rst = 0;
    press(B_INI); idle(3);
    prg = 1; step();
    repeat (3) press(B_UP);
    prg = 0; step();
    press(B_INI); idle(5);
    rst = 1; step(); rst = 0; idle(2);

    // random traffic, at most one button high per cycle
    for (int k = 0; k < 4000; k++) begin
      rst = ($urandom_range(0, 699) == 0);
      if ($urandom_range(0, 39) == 0) chs = ~chs;
      if ($urandom_range(0, 24) == 0) prg = ~prg;
      {ini, pau, up, dn, izq, der} = '0;
      r = $urandom_range(0, 11);
      if (r < 6) set_btn(r, 1'b1);
      step();
    end
    rst = 0; {ini, pau, up, dn, izq, der} = '0;
    idle(2);
    @(negedge clk); #1;
    if (total < 1000) begin
      bad++;
      $display("FAIL coverage total=%0d required>=1000", total);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
